// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit: op encodings,
// FSM state encoding, default operand width and small op-decode helpers.
package muldiv_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// EX-stage <-> multiply/divide unit bundle: request, MFHI/MFLO read, flush,
// and the status/result signals returned to the pipeline and hazard unit.
interface muldiv_seq_if #(
  parameter int WIDTH = muldiv_pkg::WIDTH_DEFAULT
);
  import muldiv_pkg::*;

  logic             start;
  op_e              op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             mf_req;
  logic             mf_sel;
  logic             flush;
  logic             busy;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mf_data;
  logic             done;
  logic             dbz;

  modport master (
    output start, op, rs_val, rt_val, mf_req, mf_sel, flush,
    input  busy, stall, hi, lo, mf_data, done, dbz
  );

  modport slave (
    input  start, op, rs_val, rt_val, mf_req, mf_sel, flush,
    output busy, stall, hi, lo, mf_data, done, dbz
  );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step (right shift of {acc,low})
// or restoring divide step (left shift, trial subtract, quotient bit into low).
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] low,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] low_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] sh;
  logic           ge;

  assign sum = {1'b0, acc} + (low[0] ? {1'b0, m} : '0);
  assign sh  = {acc, low[WIDTH-1]};
  assign ge  = (sh >= {1'b0, m});

  always_comb begin
    acc_nxt = '0;
    low_nxt = '0;
    if (is_div) begin
      // remainder is always < m here, so it fits back into WIDTH bits
      acc_nxt = ge ? WIDTH'(sh - {1'b0, m}) : sh[WIDTH-1:0];
      low_nxt = {low[WIDTH-2:0], ge};
    end else begin
      acc_nxt = sum[WIDTH:1];
      low_nxt = {sum[0], low[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential MULT/MULTU/DIV/DIVU unit: magnitudes iterated for WIDTH cycles,
// signs applied in a FIX cycle, then HI/LO written and done pulsed.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_seq_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  state_e           state;
  logic [CW-1:0]    cnt;
  op_e              op_q;
  logic             neg_q;
  logic             rs_neg_q;
  logic             div_zero;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] low;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             dbz_q;

  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] low_nxt;
  logic             sgn;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] abs_rs;
  logic [WIDTH-1:0] abs_rt;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;

  assign sgn    = op_is_signed(bus.op);
  assign sa     = sgn & bus.rs_val[WIDTH-1];
  assign sb     = sgn & bus.rt_val[WIDTH-1];
  assign abs_rs = sa ? -bus.rs_val : bus.rs_val;
  assign abs_rt = sb ? -bus.rt_val : bus.rt_val;

  assign prod     = {acc, low};
  assign prod_fix = neg_q ? -prod : prod;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (op_is_div(op_q)),
    .acc     (acc),
    .low     (low),
    .m       (m),
    .acc_nxt (acc_nxt),
    .low_nxt (low_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_q     <= OP_MULT;
      neg_q    <= 1'b0;
      rs_neg_q <= 1'b0;
      div_zero <= 1'b0;
      acc      <= '0;
      low      <= '0;
      m        <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      if (bus.flush) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.start) begin
              op_q     <= bus.op;
              neg_q    <= sa ^ sb;
              rs_neg_q <= sa;
              div_zero <= (bus.rt_val == '0);
              acc      <= '0;
              // multiply iterates over the multiplier, divide over the dividend
              low      <= op_is_div(bus.op) ? abs_rs : abs_rt;
              m        <= op_is_div(bus.op) ? abs_rt : abs_rs;
              cnt      <= CW'(WIDTH - 1);
              state    <= ST_CALC;
            end
          end
          ST_CALC: begin
            acc <= acc_nxt;
            low <= low_nxt;
            if (cnt == '0) begin
              state <= ST_FIX;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ST_FIX: begin
            if (op_is_div(op_q)) begin
              // remainder follows dividend sign; zero divisor forces all-ones quotient
              hi_q  <= rs_neg_q ? -acc : acc;
              lo_q  <= div_zero ? '1 : (neg_q ? -low : low);
              dbz_q <= div_zero;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.busy    = (state != ST_IDLE);
  assign bus.stall   = bus.busy & (bus.start | bus.mf_req);
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.mf_data = bus.mf_sel ? hi_q : lo_q;
  assign bus.done    = done_q;
  assign bus.dbz     = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: vector table of ops with hand-computed
// HI/LO/dbz, plus sequences for MF stall, start-while-busy, flush and reset.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  muldiv_seq_if #(.WIDTH(W)) bus ();

  muldiv_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    op_e         op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dbz;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.start  = 1'b0;
    bus.op     = OP_MULT;
    bus.rs_val = '0;
    bus.rt_val = '0;
    bus.mf_req = 1'b0;
    bus.mf_sel = 1'b0;
    bus.flush  = 1'b0;
  endtask

  // Issues one op and waits for done; checks latency, results and pulse width.
  task automatic run_vec(input vec_t v, input int idx);
    int n;
    bus.op     = v.op;
    bus.rs_val = v.a;
    bus.rt_val = v.b;
    bus.start  = 1'b1;
    n = 0;
    @(negedge clk);
    n++;
    bus.start = 1'b0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("v%0d_latency", idx), 64'(n), 64'd34);
    check($sformatf("v%0d_hi", idx), 64'(bus.hi), 64'(v.exp_hi));
    check($sformatf("v%0d_lo", idx), 64'(bus.lo), 64'(v.exp_lo));
    check($sformatf("v%0d_dbz", idx), 64'(bus.dbz), 64'(v.exp_dbz));
    check($sformatf("v%0d_busy_in_done", idx), 64'(bus.busy), 64'd0);
    @(negedge clk);
    check($sformatf("v%0d_done_pulse", idx), 64'(bus.done), 64'd0);
  endtask

  initial begin
    int n;
    int bad_stall;
    int seen_done;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;

    checks   = 0;
    failures = 0;

    vecs[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3] = '{OP_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1};
    vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5] = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vecs[6] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[7] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[8] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[9] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};

    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_hi",    64'(bus.hi),    64'd0);
    check("rst_lo",    64'(bus.lo),    64'd0);
    check("rst_busy",  64'(bus.busy),  64'd0);
    check("rst_done",  64'(bus.done),  64'd0);
    check("rst_dbz",   64'(bus.dbz),   64'd0);
    check("rst_stall", 64'(bus.stall), 64'd0);

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], i);
    end

    // MFHI issued mid-op plus a second start while busy; first op must complete untouched.
    bus.op     = OP_MULTU;
    bus.rs_val = 32'hFFFFFFFF;
    bus.rt_val = 32'h00000002;
    bus.start  = 1'b1;
    n = 0;
    bad_stall = 0;
    @(negedge clk);
    n++;
    bus.start = 1'b0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 3) begin
        bus.op     = OP_DIVU;
        bus.rs_val = 32'd50;
        bus.rt_val = 32'd5;
        bus.start  = 1'b1;
        #1;
        check("busy_start_stall", 64'(bus.stall), 64'd1);
      end
      if (n == 4) bus.start = 1'b0;
      if (n == 5) begin
        bus.mf_req = 1'b1;
        bus.mf_sel = 1'b1;
      end
      #1;
      if (n >= 5 && n <= 33 && bus.stall !== 1'b1) bad_stall++;
    end
    check("mf_latency",     64'(n),            64'd34);
    check("mf_stall_cycles", 64'(bad_stall),   64'd0);
    check("mf_done_stall",  64'(bus.stall),    64'd0);
    check("mf_done_data",   64'(bus.mf_data),  64'h1);
    check("mf_lo",          64'(bus.lo),       64'hFFFFFFFE);
    bus.mf_sel = 1'b0;
    #1;
    check("mf_lo_sel",      64'(bus.mf_data),  64'hFFFFFFFE);
    @(negedge clk);
    idle_inputs();
    check("busy_start_ignored", 64'(bus.busy), 64'd0);

    // Flush beats start from IDLE.
    bus.op     = OP_MULTU;
    bus.rs_val = 32'd3;
    bus.rt_val = 32'd3;
    bus.start  = 1'b1;
    bus.flush  = 1'b1;
    @(negedge clk);
    idle_inputs();
    check("flush_beats_start", 64'(bus.busy), 64'd0);

    // Flush ten cycles into an op.
    prev_hi = bus.hi;
    prev_lo = bus.lo;
    bus.op     = OP_MULTU;
    bus.rs_val = 32'd9;
    bus.rt_val = 32'd9;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_busy_before", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy_after", 64'(bus.busy), 64'd0);
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen_done++;
    end
    check("flush_no_done", 64'(seen_done), 64'd0);
    check("flush_hi_kept", 64'(bus.hi), 64'(prev_hi));
    check("flush_lo_kept", 64'(bus.lo), 64'(prev_lo));

    // Reset ten cycles into an op.
    bus.op     = OP_DIVU;
    bus.rs_val = 32'd77;
    bus.rt_val = 32'd4;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstop_busy", 64'(bus.busy), 64'd0);
    check("rstop_hi",   64'(bus.hi),   64'd0);
    check("rstop_lo",   64'(bus.lo),   64'd0);
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen_done++;
    end
    check("rstop_no_done", 64'(seen_done), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  EX-stage request to begin an op; sampled each cycle.
REQ-005 op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
REQ-006 rs_val  input  WIDTH  multiplicand / dividend.
REQ-007 rt_val  input  WIDTH  multiplier / divisor.
REQ-008 mf_req  input  1  MFHI/MFLO in EX.
REQ-009 mf_sel  input  1  0 selects LO, 1 selects HI.
REQ-010 flush  input  1  pipeline flush; aborts any op.
REQ-011 busy  output  1  high while an op is in flight.
REQ-012 stall  output  1  to hazard unit; = busy & (start | mf_req), combinational.
REQ-013 hi, lo  output  WIDTH each  architectural HI/LO registers.
REQ-014 mf_data  output  WIDTH  combinational mf_sel ? hi : lo.
REQ-015 done  output  1  one-cycle pulse on op completion.
REQ-016 dbz  output  1  divide-by-zero flag, valid with done, else 0.

Function
REQ-017 FSM states IDLE, CALC, FIX; busy = (state != IDLE).
REQ-018 IDLE & start & !flush: latch op, |rs_val|, |rt_val| (abs only for MULT/DIV), operand signs; step counter = WIDTH-1; go CALC.
REQ-019 CALC: one radix-2 step per cycle (shift-add multiply; restoring divide); counter decrements; at counter 0 go FIX; exactly WIDTH CALC cycles.
REQ-020 FIX: apply sign correction, write hi/lo, go IDLE; total busy = WIDTH+1 cycles (33 at default).
REQ-021 done and dbz registered: high in the single cycle after FIX, busy already 0 in that cycle.
REQ-022 Multiply: {hi,lo} = full 2*WIDTH product; MULT negates product when operand signs differ.
REQ-023 Divide: lo = quotient, hi = remainder; signed quotient negated when signs differ; signed remainder takes dividend sign.
REQ-024 Divisor zero (DIV/DIVU): same latency; hi = rs_val, lo = all ones, dbz = 1.
REQ-025 Signed overflow 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0, dbz = 0.
REQ-026 start while busy: ignored, no re-latch; stall holds pipeline.
REQ-027 flush in any state: next state IDLE, hi/lo unchanged, no done; flush beats start in same cycle.
REQ-028 mf_req in done cycle returns new result (no stall); mf_req while busy stalls until busy falls.
REQ-029 hi/lo change only at the FIX edge or reset.

Reset
REQ-030 rst at a clock edge, in any state: state IDLE, counter 0, hi = lo = 0, done = dbz = 0, operand/partial registers 0.
REQ-031 rst overrides start and flush; an op in flight is discarded without done.

Structure
REQ-032 Package muldiv_pkg holds op encodings, FSM state enum, WIDTH default.
REQ-033 One sub-module muldiv_step: combinational single multiply/divide iteration (add/sub + shift), instanced once in muldiv_seq.

Verification
REQ-034 MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi 0xFFFFFFFE, lo 0x00000001; done exactly 34 cycles after the start cycle.
REQ-035 MULT -3*7 -> hi 0xFFFFFFFF, lo 0xFFFFFFEB; DIV -7/2 -> lo 0xFFFFFFFD, hi 0xFFFFFFFF.
REQ-036 DIVU 7/0 -> hi 0x7, lo 0xFFFFFFFF, dbz 1; DIV 0x80000000/0xFFFFFFFF -> lo 0x80000000, hi 0.
REQ-037 mf_req (mf_sel 1) asserted 5 cycles after start -> stall 1 until done cycle, mf_data = new hi in done cycle.
REQ-038 flush 10 cycles into op -> busy 0 next cycle, hi/lo keep prior values, no done; repeat with rst -> hi=lo=0.
